// File: rtl/multi_wave_generator_if.sv
// Control and sample bus of the multi-mode waveform source.
// The master side drives run/mode controls; the slave side returns samples.
interface multi_wave_generator_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             restart;
    logic [1:0]       mode_sel;
    logic [WIDTH-1:0] wave_out;
    logic             sync_out;
    logic [1:0]       mode_act;

    modport master (output en, restart, mode_sel, input wave_out, sync_out, mode_act);
    modport slave  (input en, restart, mode_sel, output wave_out, sync_out, mode_act);
endinterface

// File: rtl/multi_wave_generator.sv
// Periodic ramp-up / ramp-down / triangle / square source with a clock-enable prescaler.
// Mode changes only take effect on a period boundary, so a period is never cut short.
module multi_wave_generator #(
    parameter int WIDTH  = 8,
    parameter int PERIOD = 40,
    parameter int DIV    = 1
) (
    input  logic                   clk1,
    input  logic                   rst,
    multi_wave_generator_if.slave  bus
);
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PH_MAX  = PW'(PERIOD - 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    typedef enum logic [1:0] {RAMP_UP, RAMP_DN, TRIANGLE, SQUARE} mode_e;
    typedef enum logic {DIR_UP, DIR_DN} dir_e;

    logic [PW-1:0]    phase_q, phase_d;
    logic [DW-1:0]    div_q, div_d;
    dir_e             dir_q, dir_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] wave_q, wave_d;
    logic             sync_q, sync_d;
    logic             tick;

    function automatic logic [WIDTH-1:0] wave_fn(input logic [PW-1:0] ph, input mode_e m);
        logic [WIDTH-1:0] v;
        case (m)
            RAMP_DN: v = WIDTH'(PERIOD - 1) - WIDTH'(ph);
            SQUARE:  v = (32'(ph) < PERIOD / 2) ? {WIDTH{1'b1}} : '0;
            default: v = WIDTH'(ph);
        endcase
        return v;
    endfunction

    assign tick = bus.en && (div_q == DIV_MAX);

    always_comb begin
        phase_d = phase_q;
        div_d   = div_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        wave_d  = wave_q;
        sync_d  = 1'b0;
        if (bus.restart) begin
            phase_d = '0;
            div_d   = '0;
            dir_d   = DIR_UP;
            mode_d  = mode_e'(bus.mode_sel);
            wave_d  = wave_fn('0, mode_d);
            sync_d  = 1'b1;
        end else if (bus.en) begin
            div_d = tick ? '0 : div_q + DW'(1);
            if (tick) begin
                if (PERIOD == 1) begin
                    phase_d = '0;
                end else if (mode_q == TRIANGLE) begin
                    // Direction flips on the tick that sits at an end point, stepping straight back.
                    if (dir_q == DIR_UP) begin
                        if (phase_q == PH_MAX) begin
                            dir_d   = DIR_DN;
                            phase_d = phase_q - PW'(1);
                        end else begin
                            phase_d = phase_q + PW'(1);
                        end
                    end else if (phase_q == '0) begin
                        dir_d   = DIR_UP;
                        phase_d = phase_q + PW'(1);
                    end else begin
                        phase_d = phase_q - PW'(1);
                    end
                end else begin
                    phase_d = (phase_q == PH_MAX) ? '0 : phase_q + PW'(1);
                end
                // Landing on phase 0 is the period start in every mode; pending mode loads here.
                if (phase_d == '0) begin
                    mode_d = mode_e'(bus.mode_sel);
                    sync_d = 1'b1;
                end
                wave_d = wave_fn(phase_d, mode_d);
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            div_q   <= '0;
            dir_q   <= DIR_UP;
            mode_q  <= RAMP_UP;
            wave_q  <= '0;
            sync_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            wave_q  <= wave_d;
            sync_q  <= sync_d;
        end
    end

    assign bus.wave_out = wave_q;
    assign bus.sync_out = sync_q;
    assign bus.mode_act = mode_q;
endmodule

// File: tb/tb_multi_wave_generator.sv
// Randomised bench for multi_wave_generator: three instances (PERIOD/DIV = 4/1, 40/3, 1/2)
// share one stimulus stream and are compared against a period-sequence reference model.
module tb_multi_wave_generator;
    localparam int N = 3;

    logic clk1 = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic restart = 1'b0;
    logic [1:0] mode_sel = 2'd0;

    logic [N-1:0][7:0] wv;
    logic [N-1:0]      sy;
    logic [N-1:0][1:0] ma;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk1 = ~clk1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int P = (g == 0) ? 4 : (g == 1) ? 40 : 1;
        localparam int D = (g == 0) ? 1 : (g == 1) ? 3 : 2;
        multi_wave_generator_if #(.WIDTH(8)) bus ();
        assign bus.en       = en;
        assign bus.restart  = restart;
        assign bus.mode_sel = mode_sel;
        multi_wave_generator #(.WIDTH(8), .PERIOD(P), .DIV(D)) dut (
            .clk1 (clk1),
            .rst  (rst),
            .bus  (bus)
        );
        assign wv[g] = bus.wave_out;
        assign sy[g] = bus.sync_out;
        assign ma[g] = bus.mode_act;
    end

    function automatic int per_of(int k);
        return (k == 0) ? 4 : (k == 1) ? 40 : 1;
    endfunction

    function automatic int div_of(int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 2;
    endfunction

    // Reference: position within the period's sample list, not a phase/direction register.
    int         m_idx  [N];
    int         m_cnt  [N];
    logic [1:0] m_mode [N];
    logic       m_sync [N];

    function automatic int seq_len(int p, logic [1:0] m);
        if (m == 2'd2) return (p == 1) ? 1 : 2 * (p - 1);
        return p;
    endfunction

    function automatic logic [7:0] exp_wave(int p, logic [1:0] m, int i);
        int ph;
        if (m == 2'd2) ph = (p == 1) ? 0 : ((i <= p - 1) ? i : 2 * (p - 1) - i);
        else           ph = i;
        case (m)
            2'd0:    return 8'(ph);
            2'd1:    return 8'(p - 1 - ph);
            2'd2:    return 8'(ph);
            default: return (ph < p / 2) ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_idx[k]  = 0;
            m_cnt[k]  = 0;
            m_mode[k] = 2'd0;
            m_sync[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            m_sync[k] = 1'b0;
            if (restart) begin
                m_idx[k]  = 0;
                m_cnt[k]  = 0;
                m_mode[k] = mode_sel;
                m_sync[k] = 1'b1;
            end else if (en) begin
                if (m_cnt[k] == div_of(k) - 1) begin
                    m_cnt[k] = 0;
                    m_idx[k] = (m_idx[k] + 1) % seq_len(per_of(k), m_mode[k]);
                    if (m_idx[k] == 0) begin
                        m_mode[k] = mode_sel;
                        m_sync[k] = 1'b1;
                    end
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("wave%0d", k), 32'(wv[k]), 32'(exp_wave(per_of(k), m_mode[k], m_idx[k])));
            chk($sformatf("sync%0d", k), 32'(sy[k]), 32'(m_sync[k]));
            chk($sformatf("mode%0d", k), 32'(ma[k]), 32'(m_mode[k]));
        end
    endtask

    task automatic cycle();
        @(posedge clk1);
        if (rst) model_reset();
        else     model_step();
        #1;
        compare_all();
    endtask

    task automatic async_reset_pulse();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        cycle();
        rst = 1'b0;
    endtask

    int   ramp_exp [6] = '{1, 2, 3, 0, 1, 2};
    logic ramp_syn [6] = '{0, 0, 0, 1, 0, 0};
    int   tri_exp  [7] = '{1, 2, 3, 2, 1, 0, 1};
    logic tri_syn  [7] = '{0, 0, 0, 0, 0, 1, 0};

    initial begin
        model_reset();
        repeat (3) cycle();
        rst = 1'b0;
        en  = 1'b1;

        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("ramp_seq", 32'(wv[0]), 32'(ramp_exp[i]));
            chk("ramp_sync", 32'(sy[0]), 32'(ramp_syn[i]));
        end

        mode_sel = 2'd2;
        restart  = 1'b1;
        cycle();
        restart = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cycle();
            chk("tri_seq", 32'(wv[0]), 32'(tri_exp[i]));
            chk("tri_sync", 32'(sy[0]), 32'(tri_syn[i]));
        end

        mode_sel = 2'd3;
        restart  = 1'b1;
        cycle();
        restart = 1'b0;
        repeat (130) cycle();

        // Mode request mid-period must wait for the wrap.
        mode_sel = 2'd0;
        restart  = 1'b1;
        cycle();
        restart = 1'b0;
        repeat (30) cycle();
        mode_sel = 2'd1;
        repeat (100) cycle();

        repeat (20) cycle();
        en      = 1'b0;
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        repeat (5) cycle();
        en = 1'b1;
        repeat (10) cycle();

        repeat (7) cycle();
        async_reset_pulse();
        repeat (6) cycle();

        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            restart = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 15) == 0) mode_sel = 2'($urandom);
            cycle();
            if ($urandom_range(0, 400) == 0) async_reset_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
